// File: rtl/sim_uart_loopback.sv
// sim_uart_loopback: clocked serial peer for the processor UART in the sim top.
// Receives frames on rxd_i, queues the bytes in an echo FIFO and sends them
// back on txd_o after TURNAROUND_CYCLES idle cycles.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   rxd_i          serial in from the DUT TXD (idle high)
//   txd_o          serial out to the DUT RXD (idle high)
//   rx_count_o     frames received with a good stop bit (32-bit, wraps)
//   tx_count_o     frames fully transmitted (32-bit, wraps)
//   fifo_level_o   echo FIFO occupancy
//   overrun_o      sticky, a received byte was dropped on a full FIFO
//   frame_error_o  sticky, bad stop bit (or bad parity)
//
// Optional feature: define SIM_UART_PARITY_EN to add an even-parity bit
// after the data bits in both directions.

module sim_uart_loopback #(
  parameter int unsigned CLK_FREQ_HZ       = 25000000,
  parameter int unsigned BAUD_RATE         = 115200,
  parameter int unsigned DATA_BITS         = 8,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter int unsigned TURNAROUND_CYCLES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rxd_i,
  output logic                          txd_o,
  output logic [31:0]                   rx_count_o,
  output logic [31:0]                   tx_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  output logic                          frame_error_o
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BIT_LAST   = 32'(BIT_CYCLES - 1);
  localparam logic [31:0] BIT_HALF   = 32'(BIT_CYCLES / 2);
  localparam logic [31:0] GAP_LAST   = 32'(TURNAROUND_CYCLES - 1);
  localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

`ifdef SIM_UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_GAP, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_GAP, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

  // Input synchroniser plus previous-value flop for falling-edge detection
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  rx_state_t   rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [31:0] rx_count_q, rx_count_d;
  logic        overrun_q, overrun_d;
  logic        ferr_q, ferr_d;
  logic        frame_ok;
`ifdef SIM_UART_PARITY_EN
  logic        rx_perr_q, rx_perr_d;
  logic        tx_par_q, tx_par_d;
`endif

  tx_state_t   tx_state_q, tx_state_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic [31:0] tx_count_q, tx_count_d;
  logic        want_next, launch;

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty, push, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef SIM_UART_PARITY_EN
  assign frame_ok = rxd_s2_q && !rx_perr_q;
`else
  assign frame_ok = rxd_s2_q;
`endif

  // Receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_count_d = rx_count_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
`ifdef SIM_UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = BIT_HALF;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rxd_s2_q) begin
            rx_state_d = RX_DATA;
            // Reload with BIT_CYCLES-1: the expiry cycle itself completes the bit period
            rx_cnt_d   = BIT_LAST;
            rx_idx_d   = '0;
            rx_shift_d = '0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d[rx_idx_q] = rxd_s2_q;
          rx_cnt_d = BIT_LAST;
          if (rx_idx_q == LAST_BIT) begin
`ifdef SIM_UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
`ifdef SIM_UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == '0) begin
          rx_perr_d  = (^rx_shift_q) ^ rxd_s2_q;
          rx_cnt_d   = BIT_LAST;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (frame_ok) begin
            rx_count_d = rx_count_q + 32'd1;
            if (!fifo_full || pop) push = 1'b1;
            else                   overrun_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmitter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_count_d = tx_count_q;
    want_next  = 1'b0;
    launch     = 1'b0;
    pop        = 1'b0;
`ifdef SIM_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: want_next = !fifo_empty;
      TX_GAP: begin
        if (tx_cnt_q == '0) launch = 1'b1;
        else                tx_cnt_d = tx_cnt_q - 32'd1;
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_cnt_d   = BIT_LAST;
        end else begin
          tx_cnt_d = tx_cnt_q - 32'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_idx_q == LAST_BIT) begin
`ifdef SIM_UART_PARITY_EN
            tx_state_d = TX_PARITY;
            txd_d      = tx_par_q;
`else
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
`endif
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 32'd1;
        end
      end
`ifdef SIM_UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
          tx_cnt_d   = BIT_LAST;
        end else begin
          tx_cnt_d = tx_cnt_q - 32'd1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_count_d = tx_count_q + 32'd1;
          tx_state_d = TX_IDLE;
          want_next  = !fifo_empty;
        end else begin
          tx_cnt_d = tx_cnt_q - 32'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Chaining straight from the stop bit keeps the inter-byte gap at exactly TURNAROUND_CYCLES
    if (want_next) begin
      if (TURNAROUND_CYCLES == 0) begin
        launch = 1'b1;
      end else begin
        tx_state_d = TX_GAP;
        tx_cnt_d   = GAP_LAST;
      end
    end
    if (launch) begin
      pop        = 1'b1;
      tx_state_d = TX_START;
      txd_d      = 1'b0;
      tx_cnt_d   = BIT_LAST;
      tx_shift_d = fifo_head;
`ifdef SIM_UART_PARITY_EN
      tx_par_d   = ^fifo_head;
`endif
    end
  end

  // Echo FIFO
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_count_q <= '0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_count_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef SIM_UART_PARITY_EN
      rx_perr_q  <= 1'b0;
      tx_par_q   <= 1'b0;
`endif
    end else begin
      rxd_s1_q   <= rxd_i;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_count_q <= rx_count_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_count_q <= tx_count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef SIM_UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign txd_o         = txd_q;
  assign rx_count_o    = rx_count_q;
  assign tx_count_o    = tx_count_q;
  assign fifo_level_o  = wr_ptr_q - rd_ptr_q;
  assign overrun_o     = overrun_q;
  assign frame_error_o = ferr_q;

endmodule

// File: tb/tb_sim_uart_loopback.sv
module tb_sim_uart_loopback;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned BITC   = 16;
  localparam int unsigned GAP_B  = 2000;
`ifdef SIM_UART_PARITY_EN
  localparam int unsigned NBITS  = 11;
`else
  localparam int unsigned NBITS  = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst = 1'b1;
  logic        rxd_a = 1'b1, rxd_b = 1'b1;
  logic        txd_a, txd_b;
  logic [31:0] rx_count_a, tx_count_a, rx_count_b, tx_count_b;
  logic [4:0]  fifo_level_a;
  logic [2:0]  fifo_level_b;
  logic        overrun_a, frame_error_a, overrun_b, frame_error_b;

  int errors = 0;
  int checks = 0;

  sim_uart_loopback #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .FIFO_DEPTH(16), .TURNAROUND_CYCLES(0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd_a), .txd_o(txd_a),
    .rx_count_o(rx_count_a), .tx_count_o(tx_count_a), .fifo_level_o(fifo_level_a),
    .overrun_o(overrun_a), .frame_error_o(frame_error_a)
  );

  sim_uart_loopback #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .FIFO_DEPTH(4), .TURNAROUND_CYCLES(GAP_B)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd_b), .txd_o(txd_b),
    .rx_count_o(rx_count_b), .tx_count_o(tx_count_b), .fifo_level_o(fifo_level_b),
    .overrun_o(overrun_b), .frame_error_o(frame_error_b)
  );

  // Frame bits in line order: start, data LSB first, [parity], stop
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop_val);
    logic [10:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
`ifdef SIM_UART_PARITY_EN
    v[9]  = ^d;
    v[10] = stop_val;
`else
    v[9]  = stop_val;
`endif
    return v;
  endfunction

  // Drives all bits up to and including setting the stop level, then returns
  task automatic drive_vec(input bit sel, input logic [10:0] v);
    for (int i = 0; i < int'(NBITS) - 1; i++) begin
      if (sel) rxd_b = v[i]; else rxd_a = v[i];
      repeat (BITC) @(negedge clk);
    end
    if (sel) rxd_b = v[NBITS-1]; else rxd_a = v[NBITS-1];
  endtask

  task automatic send_vec(input bit sel, input logic [10:0] v);
    drive_vec(sel, v);
    repeat (BITC) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd_a: got %b expected 1", txd_a); end
    checks++; if (rx_count_a !== 32'd0) begin errors++; $display("FAIL reset_rx_count_a: got %0d expected 0", rx_count_a); end
    checks++; if (tx_count_a !== 32'd0) begin errors++; $display("FAIL reset_tx_count_a: got %0d expected 0", tx_count_a); end
    checks++; if (fifo_level_a !== 5'd0) begin errors++; $display("FAIL reset_fifo_level_a: got %0d expected 0", fifo_level_a); end
    checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL reset_overrun_a: got %b expected 0", overrun_a); end
    checks++; if (frame_error_a !== 1'b0) begin errors++; $display("FAIL reset_frame_error_a: got %b expected 0", frame_error_a); end
    checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL reset_txd_b: got %b expected 1", txd_b); end
    checks++; if (fifo_level_b !== 3'd0) begin errors++; $display("FAIL reset_fifo_level_b: got %0d expected 0", fifo_level_b); end
    checks++; if (overrun_b !== 1'b0) begin errors++; $display("FAIL reset_overrun_b: got %b expected 0", overrun_b); end
  endtask

  task automatic test_echo();
    logic [10:0] exp_v;
    bit found;
    exp_v = make_frame(8'h55, 1'b1);
    drive_vec(1'b0, exp_v);
    found = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (rx_count_a == 32'd1) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL echo_rx_timeout: got rx_count=%0d expected 1 within 64 cycles", rx_count_a);
      return;
    end
    // First cycle after the push: byte queued, line still idle
    checks++; if (fifo_level_a !== 5'd1) begin errors++; $display("FAIL echo_level_after_push: got %0d expected 1", fifo_level_a); end
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL echo_idle_at_push: got %b expected 1", txd_a); end
    @(negedge clk);
    checks++; if (fifo_level_a !== 5'd0) begin errors++; $display("FAIL echo_level_after_pop: got %0d expected 0", fifo_level_a); end
    for (int k = 0; k < int'(NBITS); k++) begin
      checks++; if (txd_a !== exp_v[k]) begin errors++; $display("FAIL echo_bit%0d_first: got %b expected %b", k, txd_a, exp_v[k]); end
      repeat (BITC - 1) @(negedge clk);
      checks++; if (txd_a !== exp_v[k]) begin errors++; $display("FAIL echo_bit%0d_last: got %b expected %b", k, txd_a, exp_v[k]); end
      if (k == int'(NBITS) - 1) begin
        checks++; if (tx_count_a !== 32'd0) begin errors++; $display("FAIL echo_tx_count_in_stop: got %0d expected 0", tx_count_a); end
      end
      @(negedge clk);
    end
    checks++; if (tx_count_a !== 32'd1) begin errors++; $display("FAIL echo_tx_count: got %0d expected 1", tx_count_a); end
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL echo_idle_after: got %b expected 1", txd_a); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_error();
    send_vec(1'b0, make_frame(8'hA3, 1'b0));
    rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (frame_error_a !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_error_a); end
    checks++; if (rx_count_a !== 32'd1) begin errors++; $display("FAIL ferr_rx_count: got %0d expected 1", rx_count_a); end
    checks++; if (fifo_level_a !== 5'd0) begin errors++; $display("FAIL ferr_fifo_level: got %0d expected 0", fifo_level_a); end
    checks++; if (tx_count_a !== 32'd1) begin errors++; $display("FAIL ferr_tx_count: got %0d expected 1", tx_count_a); end
  endtask

  task automatic test_glitch();
    bit any_low;
    rxd_a = 1'b0;
    @(negedge clk);
    rxd_a = 1'b1;
    any_low = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) any_low = 1;
    end
    checks++; if (any_low !== 1'b0) begin errors++; $display("FAIL glitch_txd_quiet: got low=%b expected 0", any_low); end
    checks++; if (rx_count_a !== 32'd1) begin errors++; $display("FAIL glitch_rx_count: got %0d expected 1", rx_count_a); end
    checks++; if (fifo_level_a !== 5'd0) begin errors++; $display("FAIL glitch_fifo_level: got %0d expected 0", fifo_level_a); end
    checks++; if (frame_error_a !== 1'b1) begin errors++; $display("FAIL glitch_ferr_sticky: got %b expected 1", frame_error_a); end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    logic [7:0] exp_b;
    int t_fall, t_prev;
    bit found, any_low;
    for (int i = 1; i <= 5; i++) send_vec(1'b1, make_frame(8'(i), 1'b1));
    checks++; if (rx_count_b !== 32'd5) begin errors++; $display("FAIL ovr_rx_count: got %0d expected 5", rx_count_b); end
    checks++; if (fifo_level_b !== 3'd4) begin errors++; $display("FAIL ovr_fifo_level: got %0d expected 4", fifo_level_b); end
    checks++; if (overrun_b !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_b); end
    checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL ovr_txd_in_gap: got %b expected 1", txd_b); end
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int n = 0; n < 2500 && !found; n++) begin
        @(negedge clk);
        if (txd_b === 1'b0) found = 1;
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL ovr_echo%0d_timeout: got no start bit expected one within 2500 cycles", k);
        return;
      end
      t_fall = cyc;
      repeat (BITC / 2) @(negedge clk);
      b = '0;
      for (int i = 0; i < 8; i++) begin
        repeat (BITC) @(negedge clk);
        b[i] = txd_b;
      end
`ifdef SIM_UART_PARITY_EN
      repeat (BITC) @(negedge clk);
      checks++; if (txd_b !== ^b) begin errors++; $display("FAIL ovr_echo%0d_parity: got %b expected %b", k, txd_b, ^b); end
`endif
      repeat (BITC) @(negedge clk);
      checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL ovr_echo%0d_stop: got %b expected 1", k, txd_b); end
      exp_b = 8'(k + 1);
      checks++; if (b !== exp_b) begin errors++; $display("FAIL ovr_echo%0d_data: got %02h expected %02h", k, b, exp_b); end
      if (k > 0) begin
        checks++;
        if (t_fall - t_prev !== int'(BITC * NBITS + GAP_B)) begin
          errors++;
          $display("FAIL ovr_echo%0d_spacing: got %0d expected %0d", k, t_fall - t_prev, BITC * NBITS + GAP_B);
        end
      end
      t_prev = t_fall;
    end
    any_low = 0;
    for (int n = 0; n < 2300; n++) begin
      @(negedge clk);
      if (txd_b !== 1'b1) any_low = 1;
    end
    checks++; if (any_low !== 1'b0) begin errors++; $display("FAIL ovr_no_fifth_echo: got low=%b expected 0", any_low); end
    checks++; if (tx_count_b !== 32'd4) begin errors++; $display("FAIL ovr_tx_count: got %0d expected 4", tx_count_b); end
    checks++; if (fifo_level_b !== 3'd0) begin errors++; $display("FAIL ovr_fifo_drained: got %0d expected 0", fifo_level_b); end
  endtask

  task automatic test_reset_mid_tx();
    bit found, any_low;
    send_vec(1'b0, make_frame(8'h3C, 1'b1));
    found = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (txd_a === 1'b0) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL rstmid_echo_timeout: got no start bit expected one within 64 cycles");
      return;
    end
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b expected 1", txd_a); end
    checks++; if (tx_count_a !== 32'd0) begin errors++; $display("FAIL rstmid_tx_count: got %0d expected 0", tx_count_a); end
    checks++; if (rx_count_a !== 32'd0) begin errors++; $display("FAIL rstmid_rx_count: got %0d expected 0", rx_count_a); end
    checks++; if (fifo_level_a !== 5'd0) begin errors++; $display("FAIL rstmid_fifo_level: got %0d expected 0", fifo_level_a); end
    checks++; if (frame_error_a !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b expected 0", frame_error_a); end
    rst = 1'b0;
    any_low = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) any_low = 1;
    end
    checks++; if (any_low !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume: got low=%b expected 0", any_low); end
    checks++; if (tx_count_a !== 32'd0) begin errors++; $display("FAIL rstmid_tx_count_after: got %0d expected 0", tx_count_a); end
  endtask

`ifdef SIM_UART_PARITY_EN
  task automatic test_parity();
    logic [10:0] v;
    v = make_frame(8'h07, 1'b1);
    v[9] = 1'b0;
    send_vec(1'b0, v);
    repeat (30) @(negedge clk);
    checks++; if (frame_error_a !== 1'b1) begin errors++; $display("FAIL parity_ferr: got %b expected 1", frame_error_a); end
    checks++; if (rx_count_a !== 32'd0) begin errors++; $display("FAIL parity_rx_count: got %0d expected 0", rx_count_a); end
    checks++; if (fifo_level_a !== 5'd0) begin errors++; $display("FAIL parity_fifo_level: got %0d expected 0", fifo_level_a); end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_echo();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_mid_tx();
`ifdef SIM_UART_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
